// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader: serves the HPS upload path by reading one byte from a
// synchronous-read game RAM for each ioctl_rd strobe of the selected index. It
// holds ioctl_wait high until the byte is on ioctl_din.
//
// Ports (all on clk_sys rising edge, synchronous active-high reset):
//   ioctl_upload/ioctl_index  upload in progress / target index (selects block)
//   ioctl_rd/ioctl_addr       one-cycle read strobe and byte address from HPS
//   ioctl_din/ioctl_wait      returned byte / stall while a fetch is pending
//   mem_addr/mem_rd/mem_q     RAM read port (mem_q valid RD_LAT clocks after mem_rd)
//   active                    registered "matching upload in progress"
//   bytes_read                bytes served in current upload, saturating
//   done                      one-cycle pulse when a matching upload ends
module nvram_upload_reader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  INDEX  = 8'd4,
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  PAD    = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic              active,
  output logic [15:0]       bytes_read,
  output logic              done
);

  localparam int unsigned CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE_RD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic             end_pend;

  logic             sel;
  logic             in_range;
  logic             start_ev;
  logic             fall_ev;
  logic             served;
  logic [15:0]      count_base;

  assign sel      = ioctl_upload && (ioctl_index == INDEX);
  // Every address bit above the RAM width must be zero; no wrapping.
  assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
  assign start_ev = sel && !active;
  assign fall_ev  = active && !sel;

  // A byte is served either by a padded out-of-range read or by a completed fetch.
  assign served = (ioctl_rd && sel && !in_range && (state != FETCH)) ||
                  ((state == FETCH) && (lat_cnt == '0));

  // The counter restarts at the beginning of a matching upload.
  assign count_base = start_ev ? 16'd0 : bytes_read;

  // Fetch sequencer, counters and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      end_pend   <= 1'b0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      active     <= 1'b0;
      bytes_read <= 16'd0;
      done       <= 1'b0;
    end else begin
      active <= sel;
      mem_rd <= 1'b0;
      done   <= 1'b0;

      if (served && (count_base != 16'hFFFF)) begin
        bytes_read <= count_base + 16'd1;
      end else begin
        bytes_read <= count_base;
      end

      // An upload ending mid-fetch defers done until the fetch has completed.
      if ((fall_ev || end_pend) && (state != FETCH)) begin
        done     <= 1'b1;
        end_pend <= 1'b0;
      end else if (fall_ev) begin
        end_pend <= 1'b1;
      end

      case (state)
        IDLE, DONE_RD: begin
          state <= IDLE;
          if (ioctl_rd && sel) begin
            if (in_range) begin
              mem_addr   <= ioctl_addr[ADDR_W-1:0];
              mem_rd     <= 1'b1;
              ioctl_wait <= 1'b1;
              lat_cnt    <= LAT_INIT;
              state      <= FETCH;
            end else begin
              ioctl_din <= PAD;
            end
          end
        end
        FETCH: begin
          // Strobes arriving here are protocol violations and are dropped.
          if (lat_cnt == '0) begin
            ioctl_din  <= mem_q;
            ioctl_wait <= 1'b0;
            state      <= DONE_RD;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Bench for nvram_upload_reader: two instances (RD_LAT=1 and RD_LAT=3) on
// behavioural synchronous RAMs; served bytes are checked by a scoreboard monitor.
module tb_nvram_upload_reader;

  typedef struct {
    logic [7:0]  din;
    logic [15:0] cnt;
    int          wcyc;
    int          pulses;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        upload;
  logic [7:0]  index;
  logic        rd0, rd3;
  logic [24:0] addr;

  logic [7:0]  din0, din3;
  logic        wait0, wait3;
  logic [7:0]  maddr0, maddr3;
  logic        mrd0, mrd3;
  logic        act0, act3;
  logic [15:0] br0, br3;
  logic        done0, done3;

  logic [7:0]  mem [256];
  logic [7:0]  p0, p3a, p3b, p3c;

  // RAM models: one and three register stages of read latency.
  always @(posedge clk) begin
    p0  <= mem[maddr0];
    p3a <= mem[maddr3];
    p3b <= p3a;
    p3c <= p3b;
  end

  nvram_upload_reader #(.ADDR_W(8), .INDEX(8'd4), .RD_LAT(1), .PAD(8'hFF)) u0 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_index(index),
    .ioctl_rd(rd0), .ioctl_addr(addr), .ioctl_din(din0), .ioctl_wait(wait0),
    .mem_addr(maddr0), .mem_rd(mrd0), .mem_q(p0), .active(act0),
    .bytes_read(br0), .done(done0));

  nvram_upload_reader #(.ADDR_W(8), .INDEX(8'd4), .RD_LAT(3), .PAD(8'hFF)) u3 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_index(index),
    .ioctl_rd(rd3), .ioctl_addr(addr), .ioctl_din(din3), .ioctl_wait(wait3),
    .mem_addr(maddr3), .mem_rd(mrd3), .mem_q(p3c), .active(act3),
    .bytes_read(br3), .done(done3));

  int vectors = 0;
  int miscompares = 0;

  exp_t sb0[$];
  exp_t sb3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts wait/mem_rd cycles between served bytes and pops the scoreboard.
  int          run0 = 0, pul0 = 0, run3 = 0, pul3 = 0;
  int          dcnt0 = 0, dcnt3 = 0;
  logic        dww0 = 1'b0;
  logic [15:0] pv0, pv3;
  exp_t        e0, e3;

  always @(negedge clk) begin
    if (reset) begin
      run0 = 0; pul0 = 0; run3 = 0; pul3 = 0;
    end else begin
      if (wait0) run0++;
      if (mrd0)  pul0++;
      if (wait3) run3++;
      if (mrd3)  pul3++;
      if (done0) dcnt0++;
      if (done3) dcnt3++;
      if (done0 && wait0) dww0 = 1'b1;
      if (br0 == pv0 + 16'd1) begin
        if (sb0.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL u0_unexpected_serve: count %0d with empty queue", br0);
        end else begin
          e0 = sb0.pop_front();
          chk("u0_din", 32'(din0), 32'(e0.din));
          chk("u0_count", 32'(br0), 32'(e0.cnt));
          chk("u0_wait_cycles", 32'(run0), 32'(e0.wcyc));
          chk("u0_mem_rd_pulses", 32'(pul0), 32'(e0.pulses));
        end
        run0 = 0; pul0 = 0;
      end
      if (br3 == pv3 + 16'd1) begin
        if (sb3.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL u3_unexpected_serve: count %0d with empty queue", br3);
        end else begin
          e3 = sb3.pop_front();
          chk("u3_din", 32'(din3), 32'(e3.din));
          chk("u3_count", 32'(br3), 32'(e3.cnt));
          chk("u3_wait_cycles", 32'(run3), 32'(e3.wcyc));
          chk("u3_mem_rd_pulses", 32'(pul3), 32'(e3.pulses));
        end
        run3 = 0; pul3 = 0;
      end
    end
    pv0 = br0;
    pv3 = br3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic rd_pulse(input bit which, input logic [24:0] a);
    addr = a;
    if (which) rd3 = 1'b1;
    else       rd0 = 1'b1;
    step();
    rd0 = 1'b0;
    rd3 = 1'b0;
  endtask

  logic [7:0] first4 [4];
  int d;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    first4[0] = 8'h11; first4[1] = 8'h22; first4[2] = 8'h33; first4[3] = 8'h44;

    reset = 1'b1; upload = 1'b0; index = 8'd0; rd0 = 1'b0; rd3 = 1'b0; addr = '0;
    steps(2);
    @(negedge clk);
    chk("rst_din", 32'(din0), 32'h00);
    chk("rst_wait", 32'(wait0), 32'h0);
    chk("rst_mem_addr", 32'(maddr0), 32'h0);
    chk("rst_mem_rd", 32'(mrd0), 32'h0);
    chk("rst_active", 32'(act0), 32'h0);
    chk("rst_bytes_read", 32'(br0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_din_lat3", 32'(din3), 32'h00);

    step();
    reset = 1'b0; upload = 1'b1; index = 8'd4;
    steps(2);
    @(negedge clk);
    chk("active_rise", 32'(act0), 32'h1);

    // Four in-range reads, four cycles apart.
    for (int a = 0; a < 4; a++) begin
      sb0.push_back('{first4[a], 16'(a + 1), 2, 1});
      rd_pulse(1'b0, 25'(a));
      steps(3);
    end
    @(negedge clk);
    chk("count_after_4", 32'(br0), 32'd4);

    // Out-of-range reads pad immediately; top address bit is checked too.
    sb0.push_back('{8'hFF, 16'd5, 0, 0});
    rd_pulse(1'b0, 25'h100);
    steps(2);
    sb0.push_back('{8'hFF, 16'd6, 0, 0});
    rd_pulse(1'b0, 25'h1000000);
    steps(2);
    // Highest in-range address.
    sb0.push_back('{8'hFC, 16'd7, 2, 1});
    rd_pulse(1'b0, 25'h0FF);
    steps(3);

    // Upload end while idle.
    d = dcnt0;
    upload = 1'b0;
    steps(3);
    @(negedge clk);
    chk("done_idle_end", 32'(dcnt0 - d), 32'd1);
    chk("count_hold_after_done", 32'(br0), 32'd7);

    // Non-matching index: strobe ignored entirely.
    upload = 1'b1; index = 8'd0;
    steps(2);
    rd_pulse(1'b0, 25'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idx0_mem_rd", 32'(mrd0), 32'h0);
      chk("idx0_wait", 32'(wait0), 32'h0);
      step();
    end
    @(negedge clk);
    chk("idx0_din", 32'(din0), 32'hFC);
    chk("idx0_active", 32'(act0), 32'h0);

    // Upload ends one cycle after a strobe: fetch completes before done.
    step();
    index = 8'd4;
    steps(2);
    d = dcnt0;
    dww0 = 1'b0;
    sb0.push_back('{8'h44, 16'd1, 2, 1});
    rd_pulse(1'b0, 25'd3);
    upload = 1'b0;
    steps(5);
    @(negedge clk);
    chk("done_after_fetch", 32'(dcnt0 - d), 32'd1);
    chk("done_during_wait", 32'(dww0), 32'h0);
    chk("count_after_end", 32'(br0), 32'd1);

    // Strobe during FETCH is ignored (RD_LAT=1).
    step();
    upload = 1'b1;
    steps(2);
    sb0.push_back('{8'h22, 16'd1, 2, 1});
    rd_pulse(1'b0, 25'd1);
    rd0 = 1'b1; addr = 25'd2;
    step();
    rd0 = 1'b0;
    steps(3);

    // Same with RD_LAT=3: wait high for four cycles.
    sb3.push_back('{8'h33, 16'd1, 4, 1});
    rd_pulse(1'b1, 25'd2);
    step();
    rd3 = 1'b1; addr = 25'd0;
    step();
    rd3 = 1'b0;
    steps(5);

    // Reset in the FETCH cycle aborts the fetch.
    rd_pulse(1'b0, 25'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait", 32'(wait0), 32'h0);
    chk("rst_mid_mem_rd", 32'(mrd0), 32'h0);
    chk("rst_mid_din", 32'(din0), 32'h00);
    chk("rst_mid_count", 32'(br0), 32'd0);
    steps(3);
    sb0.push_back('{8'h22, 16'd1, 2, 1});
    rd_pulse(1'b0, 25'd1);
    steps(3);

    upload = 1'b0;
    steps(3);
    @(negedge clk);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb3_drained", 32'(sb3.size()), 32'd0);
    chk("done_total_lat1", 32'(dcnt0), 32'd3);
    chk("done_total_lat3", 32'(dcnt3), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nvram_upload_reader.md
Name: nvram_upload_reader

Overview:
- Serves the HPS upload path (ioctl_upload / ioctl_rd / ioctl_din / ioctl_wait): the read-out counterpart of the ROM download writer, used to save NVRAM/high-score bytes to SD.
- On each HPS read strobe for the selected index, it fetches one byte from a synchronous-read game RAM port and returns it on ioctl_din.
- It stalls the HPS with ioctl_wait until the byte is valid.
- It sits in emu between hps_io and the game's second RAM port, in the clk_sys domain.

Parameters:
- ADDR_W, 8, width of the RAM address; the RAM holds 2**ADDR_W bytes.
- INDEX, 8'd4, ioctl_index value that selects this block.
- RD_LAT, 1, RAM read latency in clocks (1..3).
- PAD, 8'hFF, byte returned for addresses at or beyond 2**ADDR_W.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_index  in  8  upload target index.
- ioctl_rd  in  1  one-cycle read strobe from HPS.
- ioctl_addr  in  25  byte address, valid when ioctl_rd=1.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  stalls HPS while a fetch is pending.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rd  out  1  RAM read enable, one cycle per fetch.
- mem_q  in  8  RAM read data, valid RD_LAT clocks after mem_rd.
- active  out  1  an upload with matching index is in progress.
- bytes_read  out  16  count of bytes served in the current upload; saturates at 16'hFFFF.
- done  out  1  one-cycle pulse at the end of a matching upload.

Behaviour:
- Reset values: ioctl_din=8'h00, ioctl_wait=0, mem_addr=0, mem_rd=0, active=0, bytes_read=0, done=0. FSM goes to IDLE; the latency counter is cleared.
- Reset mid-fetch aborts the fetch: no data is captured and ioctl_wait drops on the next cycle.
- sel = ioctl_upload && (ioctl_index==INDEX).
- active is a register: active <= sel.
- FSM states: IDLE, FETCH, DONE_RD.
- IDLE, on ioctl_rd && sel:
  - In range (ioctl_addr < 2**ADDR_W): mem_addr <= ioctl_addr[ADDR_W-1:0]; mem_rd <= 1 for exactly one cycle; ioctl_wait <= 1; latency counter <= RD_LAT; go to FETCH.
  - Out of range: ioctl_din <= PAD; ioctl_wait stays 0; bytes_read increments; stay in IDLE.
- FETCH: mem_rd=0; the latency counter decrements each cycle. When it reaches 0, mem_q is valid: ioctl_din <= mem_q; ioctl_wait <= 0; bytes_read increments; go to DONE_RD.
- DONE_RD: one cycle, then IDLE. ioctl_rd arriving in this cycle is accepted as if in IDLE.
- Latency: ioctl_rd at cycle T gives ioctl_wait=1 during T+1..T+1+RD_LAT, with ioctl_din valid and ioctl_wait=0 at T+2+RD_LAT.
- Throughput: one byte every RD_LAT+2 cycles maximum.
- ioctl_rd while in FETCH is a protocol violation. It is ignored: no second fetch, and the count is unchanged.
- ioctl_rd with sel=0 is ignored entirely; ioctl_din and ioctl_wait are unchanged.
- ioctl_din holds its last value until the next served read.
- Upload end: on the falling edge of active (registered sel 1 -> 0), done=1 for one cycle and bytes_read keeps its value. If a fetch is pending at that edge, it completes normally (wait drops) before done, so done may be delayed until the FSM returns to IDLE.
- Upload start: bytes_read clears to 0 on the rising edge of active.
- Address wrap: addresses are never wrapped; all bits above ADDR_W are checked.
- ioctl_wait never stays high longer than RD_LAT+1 cycles.

Test Plan:
- RAM preloaded mem[0..3]=11,22,33,44; upload index 4; ioctl_rd at addr 0..3, spaced 4 cycles apart (RD_LAT=1) -> din 11,22,33,44; wait high exactly 2 cycles each; mem_rd a single pulse each; bytes_read=4.
- ioctl_rd at addr 25'h100 with ADDR_W=8 -> din=FF on the next cycle; wait never asserted; mem_rd stays 0; bytes_read increments.
- ioctl_index=0 with ioctl_rd at addr 2 -> no mem_rd, wait=0, din unchanged, active=0.
- ioctl_upload falls one cycle after ioctl_rd to addr 3 -> fetch completes with din=44; done pulses once after wait drops; bytes_read=1.
- Second ioctl_rd asserted during FETCH -> ignored; only one mem_rd pulse; bytes_read +1. Repeat with RD_LAT=3 -> wait high 4 cycles.
- Assert reset in the FETCH cycle -> next cycle wait=0, mem_rd=0, din=00, bytes_read=0; a subsequent read at addr 1 returns 22 normally.
